// File: rtl/boot_sequencer.sv
// Board bringup sequencer: waits for PLL lock, holds the target in reset, waits for I2C
// bringup, then releases the target into user mode or the DFU bootloader.
module boot_sequencer #(
  parameter int RESET_DELAY     = 65535,
  parameter int BUTTON_DEBOUNCE = 12000,
  parameter int I2C_TIMEOUT     = 1200000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clk_locked_i,
  input  logic       pwr_button_i,
  input  logic       i2c_done_i,
  input  logic       i2c_fail_i,
  input  logic       usb_reset_i,
  input  logic [7:0] dfu_state_i,
  output logic       resetn_release_o,
  output logic       user_bootmode_o,
  output logic       usb_pull_en_o,
  output logic       dfu_reset_o,
  output logic       fault_o,
  output logic [2:0] seq_state_o
);

  // state     | meaning
  // LOCK_WAIT | waiting for synchronised PLL lock
  // DELAY     | target held in reset for RESET_DELAY+1 cycles
  // I2C_WAIT  | waiting for board I2C bringup status
  // DECIDE    | one cycle: pick user run or DFU
  // USER_RUN  | target released, running user code
  // DFU       | bootloader active, USB pull-up on
  // FAULT     | bringup failed, only a button press leaves
  typedef enum logic [2:0] {
    LOCK_WAIT = 3'd0,
    DELAY     = 3'd1,
    I2C_WAIT  = 3'd2,
    DECIDE    = 3'd3,
    USER_RUN  = 3'd4,
    DFU       = 3'd5,
    FAULT     = 3'd6
  } state_t;

  localparam int DW = (RESET_DELAY > 0)     ? $clog2(RESET_DELAY + 1)     : 1;
  localparam int BW = (BUTTON_DEBOUNCE > 0) ? $clog2(BUTTON_DEBOUNCE + 1) : 1;
  localparam int TW = (I2C_TIMEOUT > 0)     ? $clog2(I2C_TIMEOUT + 1)     : 1;

  logic          lock_s1_q, lock_s2_q;
  logic          btn_s1_q, btn_s2_q;
  logic          btn_lvl_q;
  logic [BW-1:0] db_cnt_q;
  logic          btn_differ, btn_settle, press;

  state_t        state_q;
  logic [DW-1:0] dly_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic          boot_req_q;
  logic          resetn_release_q, user_bootmode_q, usb_pull_en_q, dfu_reset_q, fault_q;

  assign btn_differ = (btn_s2_q != btn_lvl_q);
  assign btn_settle = btn_differ && ((int'(db_cnt_q) + 1) >= BUTTON_DEBOUNCE);
  // A settle while the level is still high is the 1->0 edge, i.e. the press event
  assign press      = btn_settle && btn_lvl_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
      btn_s1_q  <= 1'b0;
      btn_s2_q  <= 1'b0;
      btn_lvl_q <= 1'b1;
      db_cnt_q  <= '0;
    end else begin
      lock_s1_q <= clk_locked_i;
      lock_s2_q <= lock_s1_q;
      btn_s1_q  <= pwr_button_i;
      btn_s2_q  <= btn_s1_q;
      if (!btn_differ) begin
        db_cnt_q <= '0;
      end else if (btn_settle) begin
        btn_lvl_q <= btn_s2_q;
        db_cnt_q  <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q          <= LOCK_WAIT;
      dly_cnt_q        <= '0;
      to_cnt_q         <= '0;
      boot_req_q       <= 1'b0;
      resetn_release_q <= 1'b0;
      user_bootmode_q  <= 1'b0;
      usb_pull_en_q    <= 1'b0;
      dfu_reset_q      <= 1'b1;
      fault_q          <= 1'b0;
    end else begin
      resetn_release_q <= (state_q == USER_RUN);
      user_bootmode_q  <= (state_q == DFU);
      usb_pull_en_q    <= (state_q == DFU);
      dfu_reset_q      <= !((state_q == DFU) && !usb_reset_i);
      fault_q          <= (state_q == FAULT);

      // Lock loss wins over everything except a latched fault
      if (!lock_s2_q && (state_q != FAULT)) begin
        state_q    <= LOCK_WAIT;
        boot_req_q <= 1'b0;
      end else begin
        if (press && ((state_q == LOCK_WAIT) || (state_q == DELAY) || (state_q == I2C_WAIT)))
          boot_req_q <= 1'b1;
        case (state_q)
          LOCK_WAIT: begin
            state_q   <= DELAY;
            dly_cnt_q <= DW'(RESET_DELAY);
          end
          DELAY: begin
            if (dly_cnt_q == '0) begin
              state_q  <= I2C_WAIT;
              to_cnt_q <= '0;
            end else begin
              dly_cnt_q <= dly_cnt_q - 1'b1;
            end
          end
          I2C_WAIT: begin
            if (i2c_fail_i)                                  state_q <= FAULT;
            else if (i2c_done_i)                             state_q <= DECIDE;
            else if ((int'(to_cnt_q) + 1) >= I2C_TIMEOUT)    state_q <= FAULT;
            else                                             to_cnt_q <= to_cnt_q + 1'b1;
          end
          DECIDE: begin
            if (boot_req_q || !btn_lvl_q) begin
              boot_req_q <= 1'b1;
              state_q    <= DFU;
            end else begin
              state_q <= USER_RUN;
            end
          end
          USER_RUN: if (press) state_q <= DFU;
          DFU:      if (usb_reset_i && (dfu_state_i == 8'h01)) state_q <= USER_RUN;
          FAULT:    if (press) state_q <= DFU;
          default: begin
            state_q    <= LOCK_WAIT;
            boot_req_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign resetn_release_o = resetn_release_q;
  assign user_bootmode_o  = user_bootmode_q;
  assign usb_pull_en_o    = usb_pull_en_q;
  assign dfu_reset_o      = dfu_reset_q;
  assign fault_o          = fault_q;
  assign seq_state_o      = state_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Scoreboard bench for boot_sequencer with short delay, debounce and timeout parameters.
module tb_boot_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_locked, pwr_button, i2c_done, i2c_fail, usb_reset;
  logic [7:0] dfu_state;
  logic       resetn_release, user_bootmode, usb_pull_en, dfu_reset, fault;
  logic [2:0] seq_state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string tag;
    int    exp;
  } sb_t;
  sb_t sb_q[$];

  boot_sequencer #(
    .RESET_DELAY(4),
    .BUTTON_DEBOUNCE(3),
    .I2C_TIMEOUT(10)
  ) dut (
    .clk_i(clk),
    .reset_i(rst),
    .clk_locked_i(clk_locked),
    .pwr_button_i(pwr_button),
    .i2c_done_i(i2c_done),
    .i2c_fail_i(i2c_fail),
    .usb_reset_i(usb_reset),
    .dfu_state_i(dfu_state),
    .resetn_release_o(resetn_release),
    .user_bootmode_o(user_bootmode),
    .usb_pull_en_o(usb_pull_en),
    .dfu_reset_o(dfu_reset),
    .fault_o(fault),
    .seq_state_o(seq_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_cmp(input int obs);
    sb_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, obs, e.exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string tag, input int tgt, input int budget);
    sb_push(tag, tgt);
    for (int i = 0; i < budget && int'(seq_state) != tgt; i++) tick(1);
    sb_cmp(int'(seq_state));
  endtask

  task automatic count_state(input int st, input int budget, output int n);
    n = 0;
    while (int'(seq_state) == st && n < budget) begin
      n++;
      tick(1);
    end
  endtask

  task automatic expect_st(input string tag, input int st);
    sb_push(tag, st);
    sb_cmp(int'(seq_state));
  endtask

  task automatic expect_outs(input string tag, input int rr, input int ub, input int pu,
                             input int dr, input int fl);
    sb_push({tag, "_rr"}, rr);
    sb_push({tag, "_ub"}, ub);
    sb_push({tag, "_pu"}, pu);
    sb_push({tag, "_dr"}, dr);
    sb_push({tag, "_fl"}, fl);
    sb_cmp(int'(resetn_release));
    sb_cmp(int'(user_bootmode));
    sb_cmp(int'(usb_pull_en));
    sb_cmp(int'(dfu_reset));
    sb_cmp(int'(fault));
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #1;
    expect_st({tag, "_st"}, 0);
    expect_outs(tag, 0, 0, 0, 1, 0);
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; clk_locked = 1'b1; pwr_button = 1'b1;
    i2c_done = 1'b0; i2c_fail = 1'b0; usb_reset = 1'b0; dfu_state = 8'h00;
    tick(1);
    apply_reset("por");

    // normal boot
    wait_state("to_delay", 1, 10);
    sb_push("delay_len", 5);
    count_state(1, 20, n);
    sb_cmp(n);
    expect_st("to_i2c", 2);
    tick(3);
    i2c_done = 1'b1;
    tick(1);
    expect_st("decide", 3);
    i2c_done = 1'b0;
    tick(1);
    expect_st("user_run", 4);
    sb_push("rr_lag", 0);
    sb_cmp(int'(resetn_release));
    tick(1);
    expect_outs("user", 1, 0, 0, 1, 0);

    // bounce rejection
    repeat (4) begin
      pwr_button = 1'b0; tick(2);
      pwr_button = 1'b1; tick(1);
    end
    tick(4);
    expect_st("bounce", 4);

    // real press in USER_RUN
    pwr_button = 1'b0;
    wait_state("press_dfu", 5, 12);
    pwr_button = 1'b1;
    tick(1);
    expect_outs("dfu", 0, 1, 1, 0, 0);

    // DFU exit
    usb_reset = 1'b1; dfu_state = 8'h02;
    tick(1);
    expect_st("dfu_hold", 5);
    sb_push("dfu_rst_hold", 1);
    sb_cmp(int'(dfu_reset));
    dfu_state = 8'h01;
    tick(1);
    expect_st("dfu_exit", 4);
    usb_reset = 1'b0; dfu_state = 8'h00;
    tick(1);
    sb_push("exit_rr", 1);
    sb_cmp(int'(resetn_release));

    // lock loss in USER_RUN
    clk_locked = 1'b0;
    wait_state("lock_loss", 0, 6);
    tick(1);
    sb_push("loss_rr", 0);
    sb_cmp(int'(resetn_release));

    // button boot: press during DELAY, released before DECIDE
    clk_locked = 1'b1;
    wait_state("relock", 1, 8);
    pwr_button = 1'b0;
    tick(4);
    pwr_button = 1'b1;
    tick(6);
    expect_st("btn_i2c", 2);
    i2c_done = 1'b1;
    tick(1);
    expect_st("btn_decide", 3);
    i2c_done = 1'b0;
    tick(1);
    expect_st("btn_dfu", 5);
    tick(1);
    expect_outs("btn", 0, 1, 1, 0, 0);

    // reset in DFU
    apply_reset("mid");

    // done and fail together
    wait_state("f_i2c", 2, 20);
    i2c_done = 1'b1; i2c_fail = 1'b1;
    tick(1);
    expect_st("both_fault", 6);
    i2c_done = 1'b0; i2c_fail = 1'b0;
    tick(1);
    expect_outs("flt", 0, 0, 0, 1, 1);
    clk_locked = 1'b0;
    tick(4);
    expect_st("fault_sticky", 6);
    clk_locked = 1'b1;

    // press in FAULT
    pwr_button = 1'b0;
    wait_state("fault_press", 5, 12);
    pwr_button = 1'b1;
    tick(1);
    expect_outs("fdfu", 0, 1, 1, 0, 0);

    // I2C timeout
    apply_reset("rst3");
    wait_state("t_i2c", 2, 20);
    sb_push("i2c_len", 10);
    count_state(2, 30, n);
    sb_cmp(n);
    expect_st("timeout", 6);
    tick(1);
    sb_push("to_fault", 1);
    sb_cmp(int'(fault));

    check_eq("sb_left", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
